// File: rtl/systolic_setup.sv
// Input skew stage for one edge of the systolic array: lane j is delayed j+1
// cycles so operands enter diagonally; bubbles inject zero, ensys low clears.
module systolic_setup #(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ensys_i,
  input  logic                       bubble_i,
  input  logic [ROWS*DATA_WIDTH-1:0] data_i,
  output logic [ROWS*DATA_WIDTH-1:0] data_o,
  output logic [ROWS-1:0]            valid_o
);

  for (genvar j = 0; j < ROWS; j++) begin : g_lane
    localparam int unsigned DEPTH = j + 1;

    logic [DATA_WIDTH-1:0] dat_q [DEPTH];
    logic                  vld_q [DEPTH];
    logic [DATA_WIDTH-1:0] lane_in_c;
    logic                  vld_in_c;

    // Bubble cycles feed a zero element marked invalid.
    always_comb begin
      lane_in_c = '0;
      vld_in_c  = 1'b0;
      if (!bubble_i) begin
        lane_in_c = data_i[j*DATA_WIDTH +: DATA_WIDTH];
        vld_in_c  = 1'b1;
      end
    end

    // Reset or a dropped enable wipes the whole chain; otherwise shift by one.
    always_ff @(posedge clk_i) begin
      if (rst_i || !ensys_i) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          dat_q[i] <= '0;
          vld_q[i] <= 1'b0;
        end
      end else begin
        dat_q[0] <= lane_in_c;
        vld_q[0] <= vld_in_c;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          dat_q[i] <= dat_q[i-1];
          vld_q[i] <= vld_q[i-1];
        end
      end
    end

    assign data_o[j*DATA_WIDTH +: DATA_WIDTH] = dat_q[DEPTH-1];
    assign valid_o[j]                         = vld_q[DEPTH-1];
  end

endmodule
